// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch execution stage and its result queue.
// Holds opcode encodings, default bus widths and the result-entry layout.
// Opcodes outside the listed set resolve as not-taken with no link value.
package branch_unit_pkg;

    // Default widths; the top level takes these as parameter defaults.
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 4;
    localparam int OP_W_DEF   = 6;

    // Opcode encodings. Zero is deliberately left undefined so that an
    // all-zero (idle) opcode bus never resolves as a real branch.
    localparam logic [OP_W_DEF-1:0] OP_BEQ  = 6'd1;
    localparam logic [OP_W_DEF-1:0] OP_BNE  = 6'd2;
    localparam logic [OP_W_DEF-1:0] OP_BLT  = 6'd3;
    localparam logic [OP_W_DEF-1:0] OP_BGE  = 6'd4;
    localparam logic [OP_W_DEF-1:0] OP_BLTU = 6'd5;
    localparam logic [OP_W_DEF-1:0] OP_BGEU = 6'd6;
    localparam logic [OP_W_DEF-1:0] OP_JAL  = 6'd7;
    localparam logic [OP_W_DEF-1:0] OP_JALR = 6'd8;

    // One resolved result as it travels through the queue to the CDB.
    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
        logic                  taken;
        logic [DATA_W_DEF-1:0] target;
    } res_entry_t;

endpackage

// File: rtl/branch_result_fifo.sv
// Circular result queue: DEPTH entries of W bits, read/write pointers, count.
// Latency: a pushed entry is visible at rdata on the cycle after the push.
// Caller gates push/pop; full/almost_full flags drive upstream backpressure.
module branch_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full,
    output logic         almost_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Pointer and occupancy bookkeeping; clear wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents past the count are never observed, so no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata       = mem[rd_ptr];
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    // Asserted with one slot or fewer left, so the issuer's registered
    // request still lands in the remaining slot.
    assign almost_full = (count >= CW'(DEPTH - 1));

endmodule

// File: rtl/branch_unit.sv
// Branch/jump execute stage: resolves direction, target and link, queues results for the CDB.
// Latency 1: an instruction accepted at edge N is offered on the CDB during cycle N+1.
// in_ready drops with one slot left; offers into a full queue are dropped and flag overflow.
// Optional counters: define BRANCH_UNIT_STATS_EN for stat_resolved / stat_taken outputs.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_reg1,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_dest_tag,
    output logic              cdb_valid,
    input  logic              cdb_grant,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_taken,
    output logic [DATA_W-1:0] cdb_target,
    output logic              overflow
`ifdef BRANCH_UNIT_STATS_EN
    ,
    output logic [31:0]       stat_resolved,
    output logic [31:0]       stat_taken
`endif
);

    // Opcodes resized to the configured opcode width.
    localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] OPC_BNE  = OP_W'(OP_BNE);
    localparam logic [OP_W-1:0] OPC_BLT  = OP_W'(OP_BLT);
    localparam logic [OP_W-1:0] OPC_BGE  = OP_W'(OP_BGE);
    localparam logic [OP_W-1:0] OPC_BLTU = OP_W'(OP_BLTU);
    localparam logic [OP_W-1:0] OPC_BGEU = OP_W'(OP_BGEU);
    localparam logic [OP_W-1:0] OPC_JAL  = OP_W'(OP_JAL);
    localparam logic [OP_W-1:0] OPC_JALR = OP_W'(OP_JALR);

    // Queue entry packing: {tag, data, taken, target}.
    localparam int ENTRY_W = TAG_W + DATA_W + 1 + DATA_W;

    // ------------------------------------------------------------------
    // Resolve
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc_plus_imm;
    logic [DATA_W-1:0] reg_plus_imm;
    logic              res_taken;
    logic [DATA_W-1:0] res_target;
    logic [DATA_W-1:0] res_data;
    logic              res_is_cond;

    // All sums wrap at DATA_W bits; carries out are intentionally dropped.
    assign pc_plus4     = in_pc + DATA_W'(4);
    assign pc_plus_imm  = in_pc + in_imm;
    assign reg_plus_imm = in_reg1 + in_imm;

    // Direction, next PC and link value for the offered instruction.
    always_comb begin
        res_taken   = 1'b0;
        res_target  = pc_plus4;
        res_data    = '0;
        res_is_cond = 1'b0;
        case (in_op)
            OPC_BEQ: begin
                res_is_cond = 1'b1;
                res_taken   = (in_reg1 == in_reg2);
            end
            OPC_BNE: begin
                res_is_cond = 1'b1;
                res_taken   = (in_reg1 != in_reg2);
            end
            OPC_BLT: begin
                res_is_cond = 1'b1;
                res_taken   = ($signed(in_reg1) < $signed(in_reg2));
            end
            OPC_BGE: begin
                res_is_cond = 1'b1;
                res_taken   = ($signed(in_reg1) >= $signed(in_reg2));
            end
            OPC_BLTU: begin
                res_is_cond = 1'b1;
                res_taken   = (in_reg1 < in_reg2);
            end
            OPC_BGEU: begin
                res_is_cond = 1'b1;
                res_taken   = (in_reg1 >= in_reg2);
            end
            OPC_JAL: begin
                res_taken  = 1'b1;
                res_target = pc_plus_imm;
                res_data   = pc_plus4;
            end
            OPC_JALR: begin
                res_taken  = 1'b1;
                res_target = {reg_plus_imm[DATA_W-1:1], 1'b0};
                res_data   = pc_plus4;
            end
            default: begin
                res_taken  = 1'b0;
                res_target = pc_plus4;
                res_data   = '0;
            end
        endcase
        if (res_is_cond && res_taken) begin
            res_target = pc_plus_imm;
        end
    end

    // ------------------------------------------------------------------
    // Result queue and handshake
    // ------------------------------------------------------------------
    logic               q_empty;
    logic               q_full;
    logic               q_almost_full;
    logic               q_clear;
    logic               q_push;
    logic               q_pop;
    logic [ENTRY_W-1:0] q_wdata;
    logic [ENTRY_W-1:0] q_rdata;
    logic [ENTRY_W-1:0] head;

    // rdy gates everything, including the flush, so a stall freezes state.
    assign q_clear = rdy & clear;
    assign q_pop   = rdy & ~clear & ~q_empty & cdb_grant;
    // A full queue still accepts when the head leaves in the same cycle.
    assign q_push  = rdy & ~clear & in_valid & (~q_full | q_pop);
    assign q_wdata = {in_dest_tag, res_data, res_taken, res_target};

    branch_result_fifo #(
        .DEPTH (QDEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear       (q_clear),
        .push        (q_push),
        .pop         (q_pop),
        .wdata       (q_wdata),
        .rdata       (q_rdata),
        .empty       (q_empty),
        .full        (q_full),
        .almost_full (q_almost_full)
    );

    // Sticky drop indicator; only a flush or reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (rdy) begin
            if (clear) begin
                overflow <= 1'b0;
            end else if (in_valid && q_full && !q_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head fields read as zero whenever the queue holds nothing.
    assign head       = q_empty ? '0 : q_rdata;
    assign cdb_tag    = head[ENTRY_W-1 -: TAG_W];
    assign cdb_data   = head[2*DATA_W : DATA_W+1];
    assign cdb_taken  = head[DATA_W];
    assign cdb_target = head[DATA_W-1:0];
    assign cdb_valid  = rdy & ~q_empty;
    assign in_ready   = ~q_almost_full;

`ifdef BRANCH_UNIT_STATS_EN
    // Conditional-branch counters; they survive a flush and wrap at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved <= '0;
            stat_taken    <= '0;
        end else if (q_push && res_is_cond) begin
            stat_resolved <= stat_resolved + 32'd1;
            if (res_taken) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, corner-case
// sequences (fill/overflow, flush, stall, async reset) and random traffic,
// all compared each cycle against a queue-based reference model.
module tb_branch_unit;
    import branch_unit_pkg::*;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, in_valid, cdb_grant;
    logic        in_ready, cdb_valid, cdb_taken, overflow;
    logic [5:0]  in_op;
    logic [31:0] in_reg1, in_reg2, in_imm, in_pc;
    logic [3:0]  in_dest_tag, cdb_tag;
    logic [31:0] cdb_data, cdb_target;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_resolved, stat_taken;
`endif

    branch_unit #(.DATA_W(32), .TAG_W(4), .OP_W(6), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_reg1(in_reg1), .in_reg2(in_reg2), .in_imm(in_imm), .in_pc(in_pc),
        .in_dest_tag(in_dest_tag), .cdb_valid(cdb_valid), .cdb_grant(cdb_grant),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
        .cdb_target(cdb_target), .overflow(overflow)
`ifdef BRANCH_UNIT_STATS_EN
        , .stat_resolved(stat_resolved), .stat_taken(stat_taken)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    res_entry_t  mq[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_tk  = '0;

    function automatic bit is_cond(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
               (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

    function automatic res_entry_t ref_resolve(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] imm,
                                               input logic [31:0] pc, input logic [3:0] tag);
        res_entry_t  e;
        bit          t;
        logic [31:0] s;
        e = '0;
        e.tag = tag;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) < $signed(b));
            OP_BGE:  t = !($signed(a) < $signed(b));
            OP_BLTU: t = (a < b);
            OP_BGEU: t = !(a < b);
            OP_JAL, OP_JALR: t = 1'b1;
            default: t = 1'b0;
        endcase
        e.taken = t;
        s = a + imm;
        if (op == OP_JALR)  e.target = (s >> 1) << 1;
        else if (t)         e.target = pc + imm;
        else                e.target = pc + 32'd4;
        if (op == OP_JAL || op == OP_JALR) e.data = pc + 32'd4;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_res = '0;
        m_tk  = '0;
    endtask

    task automatic model_update();
        bit pop, full;
        res_entry_t e;
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            if (clear) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                pop  = cdb_grant && (mq.size() != 0);
                full = (mq.size() == QD);
                if (pop) void'(mq.pop_front());
                if (in_valid) begin
                    if (!full || pop) begin
                        e = ref_resolve(in_op, in_reg1, in_reg2, in_imm, in_pc, in_dest_tag);
                        mq.push_back(e);
                        if (is_cond(in_op)) begin
                            m_res = m_res + 32'd1;
                            if (e.taken) m_tk = m_tk + 32'd1;
                        end
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        res_entry_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("cdb_valid",  cdb_valid,  rdy && (mq.size() != 0));
        chk("cdb_tag",    cdb_tag,    h.tag);
        chk("cdb_data",   cdb_data,   h.data);
        chk("cdb_taken",  cdb_taken,  h.taken);
        chk("cdb_target", cdb_target, h.target);
        chk("in_ready",   in_ready,   mq.size() <= QD - 2);
        chk("overflow",   overflow,   m_ovf);
`ifdef BRANCH_UNIT_STATS_EN
        chk("stat_resolved", stat_resolved, m_res);
        chk("stat_taken",    stat_taken,    m_tk);
`endif
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        in_valid = 1'b1; in_op = op; in_reg1 = a; in_reg2 = b;
        in_imm = imm; in_pc = pc; in_dest_tag = tag;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] r1, r2, imm, pc;
        logic [3:0]  tag;
        logic        e_taken;
        logic [31:0] e_target, e_data;
    } vec_t;

    vec_t vecs[10];

    logic [5:0] ops[10];

    initial begin
        vecs[0] = '{OP_BEQ,  32'd5,        32'd5, 32'h20,       32'h100,      4'd3,  1'b1, 32'h120,      32'h0};
        vecs[1] = '{OP_BLT,  32'hFFFFFFFF, 32'd1, 32'h40,       32'h100,      4'd4,  1'b1, 32'h140,      32'h0};
        vecs[2] = '{OP_BLTU, 32'hFFFFFFFF, 32'd1, 32'h40,       32'h100,      4'd5,  1'b0, 32'h104,      32'h0};
        vecs[3] = '{OP_JALR, 32'h1001,     32'd0, 32'h4,        32'h200,      4'd6,  1'b1, 32'h1004,     32'h204};
        vecs[4] = '{OP_JAL,  32'd0,        32'd0, 32'h10,       32'hFFFFFFFC, 4'd7,  1'b1, 32'h0000000C, 32'h0};
        vecs[5] = '{OP_BNE,  32'd1,        32'd1, 32'h8,        32'h300,      4'd8,  1'b0, 32'h304,      32'h0};
        vecs[6] = '{OP_BGE,  32'h80000000, 32'd0, 32'hFFFFFFFC, 32'h400,      4'd9,  1'b0, 32'h404,      32'h0};
        vecs[7] = '{OP_BGEU, 32'h80000000, 32'd0, 32'hFFFFFFFC, 32'h400,      4'd10, 1'b1, 32'h3FC,      32'h0};
        vecs[8] = '{6'h3F,   32'd7,        32'd7, 32'h80,       32'h500,      4'd11, 1'b0, 32'h504,      32'h0};
        vecs[9] = '{OP_BEQ,  32'd9,        32'd9, 32'hFFFFFFE0, 32'h10,       4'd12, 1'b1, 32'hFFFFFFF0, 32'h0};
        ops = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, 6'h00, 6'h2A};

        rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        in_op = '0; in_reg1 = '0; in_reg2 = '0; in_imm = '0; in_pc = '0; in_dest_tag = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Directed vectors, one at a time, granted immediately.
        cdb_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].pc, vecs[i].tag);
            cycle();
            in_valid = 1'b0;
            sample();
            chk("vec_valid",  cdb_valid,  1'b1);
            chk("vec_tag",    cdb_tag,    vecs[i].tag);
            chk("vec_taken",  cdb_taken,  vecs[i].e_taken);
            chk("vec_target", cdb_target, vecs[i].e_target);
            chk("vec_data",   cdb_data,   vecs[i].e_data);
            tick();
        end

        // Fill with grant low: in_ready drops after 3, the 5th offer overflows.
        cdb_grant = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(OP_BNE, k, 0, 32'h8, 32'h1000 + 32'(k), 4'(k));
            sample();
            if (k == 3) chk("fill_ready_2", in_ready, 1'b1);
            if (k == 4) chk("fill_ready_3", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        sample();
        chk("fill_overflow", overflow, 1'b1);
        chk("fill_head",     cdb_tag,  4'd1);
        tick();
        cdb_grant = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sample();
            chk("drain_order", cdb_tag, 4'(k));
            tick();
        end
        sample();
        chk("drain_empty", cdb_valid, 1'b0);
        tick();

        // Flush with two entries queued and an offer in the same cycle.
        cdb_grant = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(OP_JAL, 0, 0, 32'h40, 32'h2000, 4'(13 + k));
            cycle();
        end
        clear = 1'b1;
        drive(OP_BEQ, 1, 1, 4, 32'h3000, 4'd15);
        cycle();
        clear = 1'b0; in_valid = 1'b0;
        sample();
        chk("clr_valid",    cdb_valid, 1'b0);
        chk("clr_overflow", overflow,  1'b0);
        chk("clr_ready",    in_ready,  1'b1);
        tick();

        // Full queue with a pop accepts a new entry without overflow.
        for (int k = 0; k < 4; k++) begin
            drive(OP_BLTU, 0, 1, 32'h10, 32'h4000, 4'(8 + k));
            cycle();
        end
        cdb_grant = 1'b1;
        drive(OP_BGEU, 0, 1, 32'h10, 32'h4000, 4'd12);
        cycle();
        in_valid = 1'b0; cdb_grant = 1'b0;
        sample();
        chk("fullpop_ovf",  overflow, 1'b0);
        chk("fullpop_head", cdb_tag,  4'd9);
        tick();

        // Stall: rdy low hides the head and blocks push, pop and overflow.
        rdy = 1'b0; cdb_grant = 1'b1;
        drive(OP_BEQ, 0, 0, 0, 0, 4'd1);
        cycle();
        cycle();
        sample();
        chk("stall_valid", cdb_valid, 1'b0);
        chk("stall_ovf",   overflow,  1'b0);
        tick();
        rdy = 1'b1; in_valid = 1'b0; cdb_grant = 1'b0;
        sample();
        chk("stall_held", cdb_tag, 4'd9);
        tick();

        // Asynchronous reset between edges with a non-empty queue.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid",  cdb_valid,  1'b0);
        chk("arst_ready",  in_ready,   1'b1);
        chk("arst_target", cdb_target, 32'h0);
        check_outputs();
        tick();
        rst = 1'b0;
        cycle();

        // Random traffic in three phases of differing grant pressure.
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 300; n++) begin
                logic [31:0] a;
                a         = $urandom;
                rdy       = ($urandom_range(0, 9) != 0);
                clear     = ($urandom_range(0, 39) == 0);
                cdb_grant = (ph == 0) ? ($urandom_range(0, 3) != 0) :
                            (ph == 1) ? ($urandom_range(0, 3) == 0) : 1'b1;
                drive(ops[$urandom_range(0, 9)], a,
                      ($urandom_range(0, 2) == 0) ? a : $urandom,
                      ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom,
                      $urandom & 32'hFFFFFFFC, 4'($urandom));
                in_valid = ($urandom_range(0, 3) != 0);
                cycle();
            end
        end
        rdy = 1'b1; clear = 1'b0; in_valid = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch/jump execution stage directly downstream of the branch reservation station. Each cycle it accepts at most one ready-operand branch/jump instruction and resolves direction, target and link value. Results go into a small result queue, which drives the CDB/ROB under a grant handshake. The queue also back-pressures the reservation station.

## Interface
Parameters:
- DATA_W, 32, operand/PC/result width
- TAG_W, 4, ROB tag width
- OP_W, 6, opcode width
- QDEPTH, 4, result-queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- clear  in  1  synchronous flush (mispredict).
- in_valid  in  1  instruction offered by the reservation station.
- in_ready  out  1  unit can accept next cycle.
- in_op  in  OP_W  opcode.
- in_reg1, in_reg2  in  DATA_W  resolved operands.
- in_imm  in  DATA_W  sign-extended immediate.
- in_pc  in  DATA_W  instruction PC.
- in_dest_tag  in  TAG_W  ROB tag.
- cdb_valid  out  1  queue head valid.
- cdb_grant  in  1  CDB arbiter accepts head this cycle.
- cdb_tag  out  TAG_W  head ROB tag.
- cdb_data  out  DATA_W  link value (pc+4) for JAL/JALR, 0 for conditional branches.
- cdb_taken  out  1  resolved direction (1 for jumps).
- cdb_target  out  DATA_W  next PC.
- overflow  out  1  sticky: an instruction was offered while the queue was full.

## Operation
- Combinational resolve on inputs:
  - BEQ/BNE: equality.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - JAL: taken, target pc+imm.
  - JALR: taken, target (reg1+imm) & ~1.
  - Conditional branches: target pc+imm if taken, else pc+4.
  - All adds are DATA_W-bit with wrap-around, no carry out.
  - Undefined opcode: taken=0, target=pc+4, data=0.
- Result queue: circular, QDEPTH entries, read/write pointers plus a count of width log2(QDEPTH)+1.
- Push when rdy & in_valid & count<QDEPTH.
- Pop when rdy & cdb_valid & cdb_grant.
- Simultaneous push and pop: count unchanged; full queue with pop allows push the same cycle.
- in_valid while count==QDEPTH: instruction dropped and overflow set. Only rst or clear clears overflow.
- in_ready = (count ≤ QDEPTH-2). One slot of headroom absorbs the reservation station's registered issue.
- cdb_valid = rdy & (count≠0). cdb_tag, cdb_data, cdb_taken and cdb_target come combinationally from the head entry; all are 0 when the queue is empty.
- clear has priority over push/pop: pointers and count go to 0 and overflow to 0. The input offered in the same cycle is discarded.
- Reset (asynchronous): pointers and count go to 0, overflow=0. in_ready=1 and cdb_valid=0; every other output is 0.

## Timing
- Latency 1: an instruction sampled at edge N is presented on the CDB during cycle N+1. It stays presented until the edge at which cdb_grant is high.
- Throughput: 1 instruction/cycle when cdb_grant is held high.
- in_ready updates in the cycle after the count change.
- rdy low: no push, no pop, state holds, cdb_valid=0, overflow not set.
- rst asserted mid-operation empties the queue immediately; no partial entry survives.

## Configuration
- BRANCH_UNIT_STATS_EN defined: adds a 32-bit output stat_resolved and a 32-bit output stat_taken.
  - stat_resolved counts pushes of conditional branches; stat_taken counts those that were taken.
  - Both wrap at 2^32, reset to 0 on rst, and are unaffected by clear.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Shared package:
  - Opcode encodings for BEQ..BGEU, JAL and JALR.
  - DATA_W/TAG_W/OP_W defaults.
  - A result-entry struct {tag, data, taken, target}.
- Sub-module branch_result_fifo:
  - Queue storage, pointers, count and full/empty/almost-full flags, parameterised by QDEPTH and entry width.
- The top level holds the resolve logic, handshake glue and optional counters.

## Test plan
- BEQ reg1=reg2=5, pc=0x100, imm=0x20, tag=3, grant high → next cycle cdb_valid=1, tag=3, taken=1, target=0x120, data=0.
- BLT reg1=0xFFFFFFFF, reg2=1 → taken=1. BLTU with the same operands → taken=0, target=pc+4.
- JALR reg1=0x1001, imm=0x4, pc=0x200 → target=0x1004, data=0x204, taken=1. JAL with pc=0xFFFFFFFC → data=0x00000000 (wrap).
- grant held low, five back-to-back pushes with QDEPTH=4 → in_ready drops after 3 entries. The 5th push sets overflow and 4 entries are retained. Granting then drains them in FIFO tag order.
- Queue holding 2 entries, clear and in_valid in the same cycle → next cycle cdb_valid=0, count=0, overflow=0, in_ready=1.
- rst pulsed asynchronously between edges while the queue is non-empty → outputs immediately at reset values. With BRANCH_UNIT_STATS_EN, stat_resolved=0 and stat_taken=0.
